unidade_es_parametrizada: RTL and testbench

Parametrised successor to the single-port input/output path of the processing unit. It services IN and OUT instructions over a configurable data width and a configurable number of output channels. IN is a real handshake: the block stalls the PC until a debounced press of the confirm button, then delivers the switch value exactly once. Sits between the control unit / register bank and the board switches, button and display drivers.

---
 rtl/unidade_es_pkg.sv | 14 +
 rtl/debounce_botao.sv | 58 +++++
 rtl/unidade_es_parametrizada.sv | 181 ++++++++++++++++++
 tb/tb_unidade_es_parametrizada.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/unidade_es_pkg.sv
// Shared definitions for the parametrised I/O unit: IN handshake state encoding
// and the idle level of the active-low confirm button.
package unidade_es_pkg;

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_WAIT_PRESS   = 2'd1,
    ST_DONE         = 2'd2,
    ST_WAIT_RELEASE = 2'd3
  } es_state_e;

  localparam logic BTN_RELEASED = 1'b1;

endpackage

// File: rtl/debounce_botao.sv
// Confirm-button conditioning: 2-flop synchroniser followed by a debouncer that
// accepts a new level only after DEBOUNCE_CYCLES consecutive differing samples.
module debounce_botao
  import unidade_es_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic btn_i,
  output logic level_o,
  output logic press_o
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    level_d = level_q;
    cnt_d   = cnt_q;
    press_d = 1'b0;
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      level_d = sync2_q;
      cnt_d   = '0;
      // press is the falling edge of the debounced level only
      press_d = ~sync2_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_q <= BTN_RELEASED;
      sync2_q <= BTN_RELEASED;
      level_q <= BTN_RELEASED;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o = level_q;
  assign press_o = press_q;

endmodule

// File: rtl/unidade_es_parametrizada.sv
// Parametrised IN/OUT unit: IN stalls until a fresh debounced button press, OUT
// writes one of N_OUT channel registers. Optional IO_TIMEOUT_EN bounds the IN wait.
//  state        | meaning
//  IDLE         | no IN instruction being serviced
//  WAIT_PRESS   | IN pending, waiting for a fresh debounced press
//  DONE         | in_valid pulse, in_data holds the captured switches
//  WAIT_RELEASE | press consumed, waiting for the button to be released
module unidade_es_parametrizada
  import unidade_es_pkg::*;
#(
  parameter int DATA_W          = 32,
  parameter int IN_W            = 4,
  parameter int N_OUT           = 2,
  parameter int SEL_W           = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    in_req,
  input  logic                    out_req,
  input  logic [SEL_W-1:0]        port_sel,
  input  logic [DATA_W-1:0]       out_data,
  input  logic [IN_W-1:0]         switches,
  input  logic                    check,
  output logic                    stall,
  output logic                    in_valid,
  output logic [DATA_W-1:0]       in_data,
  output logic [N_OUT*DATA_W-1:0] out_ports,
  output logic [N_OUT-1:0]        out_valid,
  output logic                    out_err,
  output logic                    in_timeout
);

  if (N_OUT < 1 || (2 ** SEL_W) < N_OUT || DATA_W < IN_W ||
      DEBOUNCE_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("unidade_es_parametrizada: inconsistent parameters");
  end

  logic [IN_W-1:0]   sw_s1_q, sw_s2_q;
  logic              btn_level, btn_press;
  logic              tmo_hit;
  es_state_e         state_q, state_d;
  logic [DATA_W-1:0] in_data_q, in_data_d;
  logic [DATA_W-1:0] ports_q [N_OUT];
  logic [N_OUT-1:0]  out_valid_q, out_valid_d;
  logic              out_err_q, out_err_d;

  debounce_botao #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clock   (clock),
    .reset   (reset),
    .btn_i   (check),
    .level_o (btn_level),
    .press_o (btn_press)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sw_s1_q <= '0;
      sw_s2_q <= '0;
    end else begin
      sw_s1_q <= switches;
      sw_s2_q <= sw_s1_q;
    end
  end

`ifdef IO_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             in_timeout_q;

  // reloads outside WAIT_PRESS so every wait gets the full budget
  always_comb begin
    tmo_d = TMO_LAST;
    if (state_q == ST_WAIT_PRESS && tmo_q != '0) tmo_d = tmo_q - 1'b1;
  end

  assign tmo_hit = (state_q == ST_WAIT_PRESS) && in_req && !btn_press && (tmo_q == '0);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tmo_q        <= TMO_LAST;
      in_timeout_q <= 1'b0;
    end else begin
      tmo_q        <= tmo_d;
      in_timeout_q <= in_timeout_q | tmo_hit;
    end
  end

  assign in_timeout = in_timeout_q;
`else
  assign tmo_hit    = 1'b0;
  assign in_timeout = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    in_data_d = in_data_q;
    case (state_q)
      ST_IDLE: begin
        if (in_req) state_d = ST_WAIT_PRESS;
      end
      ST_WAIT_PRESS: begin
        if (!in_req) begin
          state_d = ST_IDLE;
        end else if (btn_press) begin
          in_data_d = DATA_W'(sw_s2_q);
          state_d   = ST_DONE;
        end else if (tmo_hit) begin
          in_data_d = '0;
          state_d   = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_WAIT_RELEASE;
      end
      ST_WAIT_RELEASE: begin
        if (btn_level == BTN_RELEASED) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      in_data_q <= '0;
    end else begin
      state_q   <= state_d;
      in_data_q <= in_data_d;
    end
  end

  assign in_valid = (state_q == ST_DONE);
  assign stall    = in_req & ~in_valid;
  assign in_data  = in_data_q;

  always_comb begin
    out_valid_d = '0;
    out_err_d   = 1'b0;
    if (out_req) begin
      if (int'(port_sel) < N_OUT) begin
        for (int k = 0; k < N_OUT; k++) begin
          if (int'(port_sel) == k) out_valid_d[k] = 1'b1;
        end
      end else begin
        out_err_d = 1'b1;
      end
    end
  end

  // the write strobe for a channel doubles as next cycle's out_valid bit
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < N_OUT; k++) ports_q[k] <= '0;
      out_valid_q <= '0;
      out_err_q   <= 1'b0;
    end else begin
      for (int k = 0; k < N_OUT; k++) begin
        if (out_valid_d[k]) ports_q[k] <= out_data;
      end
      out_valid_q <= out_valid_d;
      out_err_q   <= out_err_d;
    end
  end

  always_comb begin
    out_ports = '0;
    for (int k = 0; k < N_OUT; k++) out_ports[k*DATA_W +: DATA_W] = ports_q[k];
  end

  assign out_valid = out_valid_q;
  assign out_err   = out_err_q;

endmodule

// File: tb/tb_unidade_es_parametrizada.sv
// Scoreboard bench for unidade_es_parametrizada: stimulus pushes expected IN/OUT
// transactions, a monitor pops and compares whenever the DUT presents a result.
module tb_unidade_es_parametrizada;

  localparam int DW = 32;
  localparam int IW = 4;
  localparam int NO = 2;
  localparam int SW = 2;
  localparam int DB = 4;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             in_req = 1'b0;
  logic             out_req = 1'b0;
  logic [SW-1:0]    port_sel = '0;
  logic [DW-1:0]    out_data = '0;
  logic [IW-1:0]    switches = '0;
  logic             check = 1'b1;
  logic             stall;
  logic             in_valid;
  logic [DW-1:0]    in_data;
  logic [NO*DW-1:0] out_ports;
  logic [NO-1:0]    out_valid;
  logic             out_err;
  logic             in_timeout;

  unidade_es_parametrizada #(
    .DATA_W(DW), .IN_W(IW), .N_OUT(NO), .SEL_W(SW),
    .DEBOUNCE_CYCLES(DB), .TIMEOUT_CYCLES(1024)
  ) dut (
    .clock(clock), .reset(reset), .in_req(in_req), .out_req(out_req),
    .port_sel(port_sel), .out_data(out_data), .switches(switches), .check(check),
    .stall(stall), .in_valid(in_valid), .in_data(in_data), .out_ports(out_ports),
    .out_valid(out_valid), .out_err(out_err), .in_timeout(in_timeout)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit               is_err;
    int               ch;
    logic [NO*DW-1:0] ports;
  } out_exp_t;

  logic [DW-1:0] in_exp_q[$];
  out_exp_t      out_exp_q[$];
  logic [DW-1:0] ch_model [NO];
  int            n_cmp = 0;
  int            n_bad = 0;
  int            in_seen = 0;
  bit            auto_drop = 1'b1;

  task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic monitor();
    out_exp_t e;
    logic [NO-1:0] vexp;
    forever begin
      @(negedge clock);
      if (reset) begin
        check_eq("stall_rule", stall, in_req & ~in_valid);
`ifndef IO_TIMEOUT_EN
        check_eq("in_timeout_zero", in_timeout, 1'b0);
`endif
        if (in_valid) begin
          in_seen++;
          if (in_exp_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL in_unexpected: in_data %h with no IN pending", in_data);
          end else begin
            check_eq("in_data", in_data, in_exp_q.pop_front());
          end
        end
        if (out_valid != '0 || out_err) begin
          if (out_exp_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL out_unexpected: out_valid %b out_err %b with no OUT pending", out_valid, out_err);
          end else begin
            e = out_exp_q.pop_front();
            vexp = '0;
            if (!e.is_err) vexp[e.ch] = 1'b1;
            check_eq("out_err", out_err, e.is_err);
            check_eq("out_valid", out_valid, vexp);
            check_eq("out_ports", out_ports, e.ports);
          end
        end
      end
    end
  endtask

  task automatic issue_out(input logic [SW-1:0] sel, input logic [DW-1:0] d);
    out_exp_t e;
    out_req  = 1'b1;
    port_sel = sel;
    out_data = d;
    e.is_err = (int'(sel) >= NO);
    e.ch     = int'(sel);
    if (!e.is_err) ch_model[int'(sel)] = d;
    e.ports = '0;
    for (int k = 0; k < NO; k++) e.ports[k*DW +: DW] = ch_model[k];
    out_exp_q.push_back(e);
  endtask

  // one clock step; the control unit drops in_req the cycle after in_valid
  task automatic tick(input bit rnd_out);
    logic v;
    @(negedge clock);
    v = in_valid;
    @(posedge clock);
    #1;
    out_req = 1'b0;
    if (v && auto_drop) in_req = 1'b0;
    if (rnd_out && $urandom_range(0, 2) == 0)
      issue_out(SW'($urandom_range(0, 3)), $urandom);
  endtask

  task automatic press(input int low_cycles, input bit rnd_out);
    check = 1'b0;
    repeat (low_cycles) tick(rnd_out);
    check = 1'b1;
  endtask

  task automatic wait_in(input int start, input int budget, input bit rnd_out, input string name);
    int n;
    n = 0;
    while (in_seen <= start && n < budget) begin
      tick(rnd_out);
      n++;
    end
    n_cmp++;
    if (in_seen <= start) begin
      n_bad++;
      $display("FAIL %s_timeout: no in_valid within %0d cycles", name, budget);
    end
  endtask

  task automatic start_in(input logic [IW-1:0] sw, output int start);
    switches = sw;
    in_req   = 1'b1;
    start    = in_seen;
    in_exp_q.push_back(DW'(sw));
  endtask

  initial begin
    int start;
    logic [IW-1:0] sw;
    for (int k = 0; k < NO; k++) ch_model[k] = '0;
    fork
      monitor();
    join_none

    // reset state
    repeat (3) @(posedge clock);
    #1;
    check_eq("rst_in_valid", in_valid, 1'b0);
    check_eq("rst_in_data", in_data, '0);
    check_eq("rst_out_ports", out_ports, '0);
    check_eq("rst_out_valid", out_valid, '0);
    check_eq("rst_out_err", out_err, 1'b0);
    check_eq("rst_in_timeout", in_timeout, 1'b0);
    reset = 1'b1;
    repeat (4) tick(1'b0);
    check_eq("idle_stall", stall, 1'b0);
    check_eq("idle_out_ports", out_ports, '0);

    // basic IN: press for 10 cycles
    auto_drop = 1'b1;
    start_in(4'hA, start);
    repeat (3) tick(1'b0);
    check_eq("in_a_stall_wait", stall, 1'b1);
    press(10, 1'b0);
    wait_in(start, 20, 1'b0, "in_a");
    repeat (10) tick(1'b0);
    check_eq("in_a_single_pulse", in_seen, start + 1);

    // back-to-back IN with the button held low across both
    auto_drop = 1'b0;
    start_in(4'h5, start);
    check = 1'b0;
    wait_in(start, 20, 1'b0, "b2b_first");
    switches = 4'h3;
    in_exp_q.push_back(DW'(4'h3));
    repeat (12) tick(1'b0);
    check_eq("b2b_held_stall", stall, 1'b1);
    check_eq("b2b_held_no_in", in_seen, start + 1);
    check = 1'b1;
    repeat (12) tick(1'b0);
    check_eq("b2b_released_stall", stall, 1'b1);
    check_eq("b2b_released_no_in", in_seen, start + 1);
    auto_drop = 1'b1;
    press(8, 1'b0);
    wait_in(start + 1, 20, 1'b0, "b2b_second");
    repeat (10) tick(1'b0);

    // short glitch is not a press
    start_in(4'($urandom_range(0, 15)), start);
    repeat (3) tick(1'b0);
    press(2, 1'b0);
    repeat (10) tick(1'b0);
    check_eq("glitch_stall", stall, 1'b1);
    check_eq("glitch_no_in", in_seen, start);
    press(7, 1'b0);
    wait_in(start, 20, 1'b0, "glitch_recover");
    repeat (10) tick(1'b0);

    // directed OUT, then an out-of-range channel
    issue_out(2'd1, 32'hDEADBEEF);
    tick(1'b0);
    tick(1'b0);
    issue_out(2'd3, 32'h12345678);
    tick(1'b0);
    tick(1'b0);
    issue_out(2'd0, 32'h0BADF00D);
    tick(1'b0);
    tick(1'b0);

    // randomized IN transactions with OUT traffic interleaved
    for (int i = 0; i < 8; i++) begin
      sw = 4'($urandom_range(0, 15));
      start_in(sw, start);
      repeat ($urandom_range(0, 5)) tick(1'b1);
      press($urandom_range(6, 12), 1'b1);
      wait_in(start, 30, 1'b1, "rand_in");
      repeat (8) tick(1'b1);
    end
    for (int i = 0; i < 30; i++) tick(1'b1);
    repeat (4) tick(1'b0);

    // reset while waiting for a press
    in_req   = 1'b1;
    switches = 4'h9;
    start    = in_seen;
    repeat (4) tick(1'b0);
    check_eq("pre_rst_stall", stall, 1'b1);
    reset  = 1'b0;
    in_req = 1'b0;
    #1;
    check_eq("mid_rst_in_valid", in_valid, 1'b0);
    check_eq("mid_rst_out_ports", out_ports, '0);
    check_eq("mid_rst_in_data", in_data, '0);
    for (int k = 0; k < NO; k++) ch_model[k] = '0;
    @(posedge clock);
    #1;
    reset = 1'b1;
    repeat (15) tick(1'b0);
    check_eq("post_rst_no_in", in_seen, start);

    // recovery after reset
    start_in(4'h7, start);
    repeat (2) tick(1'b0);
    press(8, 1'b0);
    wait_in(start, 20, 1'b0, "post_rst_in");
    repeat (10) tick(1'b0);

    check_eq("in_queue_drained", in_exp_q.size(), 0);
    check_eq("out_queue_drained", out_exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
